id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit data, 5-bit register index and 3-bit ALU function.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rd1_d, rd2_d  in  32  register-file read data from decode.
REQ-005 signimm_d  in  32  sign-extended immediate from decode.
REQ-006 rs_d, rt_d, rd_d  in  5  decode register indices.
REQ-007 regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d  in  1 each  decode control bits.
REQ-008 alucontrol_d  in  3  ALU function code for the instruction in decode.
REQ-009 flush_e  in  1  branch-taken kill; bubble enters EX on the next edge.
REQ-010 aluout_m, result_w  in  32  forwarding data from MEM and WB.
REQ-011 writereg_m, writereg_w  in  5; regwrite_m, regwrite_w  in  1  forwarding destinations and write enables.
REQ-012 srca_e, srcb_e  out  32  ALU operands a and b.
REQ-013 alucontrol_e  out  3  ALU f input.
REQ-014 writedata_e  out  32  forwarded rt value for stores.
REQ-015 writereg_e  out  5; regwrite_e, memtoreg_e, memwrite_e  out  1  passed to EX/MEM.
REQ-016 stall_d  out  1  load-use stall request to fetch/decode (combinational).

Function
REQ-017 On each rising edge without stall_d or flush_e, the EX register SHALL capture all *_d inputs; one-cycle latency from decode to EX outputs.
REQ-018 When stall_d or flush_e is 1 at an edge, the EX register SHALL load a bubble: all data, index and control fields zero, alucontrol 3'b010.
REQ-019 Simultaneous stall_d and flush_e SHALL produce a single bubble, identical to either alone.
REQ-020 stall_d SHALL be 1 iff memtoreg_e=1, rt_e!=0 and (rt_e==rs_d or rt_e==rt_d).
REQ-021 writereg_e SHALL be rd_e when regdst_e=1, else rt_e.
REQ-022 Forward select for A (from rs_e) SHALL be: MEM if regwrite_m and writereg_m==rs_e and rs_e!=0; else WB if regwrite_w and writereg_w==rs_e and rs_e!=0; else rd1_e.
REQ-023 Forward select for B SHALL use the same rule on rt_e with rd2_e as default; MEM has priority over WB when both match.
REQ-024 Register 0 SHALL never be forwarded; regwrite low SHALL suppress forwarding regardless of index match.
REQ-025 srca_e SHALL be forwarded A; writedata_e SHALL be forwarded B; srcb_e SHALL be signimm_e when alusrc_e=1, else forwarded B.
REQ-026 Forwarding and operand muxing SHALL be purely combinational from EX register and MEM/WB inputs (same-cycle).

Reset
REQ-027 Asserting reset SHALL immediately clear the EX register to the bubble value of REQ-018, so all control outputs are 0, alucontrol_e=3'b010, stall_d=0.
REQ-028 Reset mid-operation SHALL discard the in-flight instruction; the first edge after deassert captures decode normally.

Structure
REQ-029 A shared package mips_pkg SHALL hold the ALU function encodings (AND 000, OR 001, ADD 010, ANDN 100, ORN 101, SUB 110, SLT 111), the bubble ALU code, and the data/index width constants.
REQ-030 Forwarding compare logic SHALL be one sub-module, forward_unit, instantiated twice (A and B).

Verification
REQ-031 Pass-through: rd1_d=5, rd2_d=7, alucontrol_d=010, alusrc_d=0 -> next cycle srca_e=5, srcb_e=7, alucontrol_e=010.
REQ-032 Double forward: rs_e=rt_e=3, writereg_m=3 regwrite_m=1 aluout_m=0x11, writereg_w=3 regwrite_w=1 result_w=0x22 -> srca_e=srcb_e=0x11; drop regwrite_m -> both 0x22.
REQ-033 $0 guard: rs_e=0, writereg_m=0, regwrite_m=1, aluout_m=0xFF, rd1_e=0 -> srca_e=0.
REQ-034 Load-use: EX holds lw with rt_e=4, decode rs_d=4 -> stall_d=1, next cycle regwrite_e=memwrite_e=memtoreg_e=0; decode held instruction enters EX one cycle later.
REQ-035 Flush with stall: flush_e=1 while stall_d=1 -> exactly one bubble, alucontrol_e=010.
REQ-036 Async reset: assert reset between edges with regwrite_e=1 -> regwrite_e=0 before next edge; alusrc_d=1, signimm_d=0xFFFFFFFC after deassert -> srcb_e=0xFFFFFFFC.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared widths, ALU function encodings and the ID/EX register type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALU_W  = 3;

    typedef enum logic [ALU_W-1:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    localparam alu_op_e ALU_BUBBLE = ALU_ADD;

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signimm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic              alusrc;
        logic              regdst;
        logic [ALU_W-1:0]  alucontrol;
    } ex_reg_t;

    // A bubble is an all-zero instruction that still presents ADD to the ALU.
    function automatic ex_reg_t ex_bubble();
        ex_reg_t b;
        b            = '0;
        b.alucontrol = ALU_BUBBLE;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module   : forward_unit
// Brief    : Selects one EX operand from MEM, WB or the register-file value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module forward_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0]  src_idx_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              regwrite_m_i,
    input  logic [REG_W-1:0]  writereg_m_i,
    input  logic [DATA_W-1:0] aluout_m_i,
    input  logic              regwrite_w_i,
    input  logic [REG_W-1:0]  writereg_w_i,
    input  logic [DATA_W-1:0] result_w_i,
    output logic [DATA_W-1:0] data_o
);

    logic w_nonzero;
    logic w_hit_m;
    logic w_hit_w;

    // $0 is hardwired, so a write targeting it must never be forwarded.
    assign w_nonzero = (src_idx_i != '0);
    assign w_hit_m   = regwrite_m_i && (writereg_m_i == src_idx_i) && w_nonzero;
    assign w_hit_w   = regwrite_w_i && (writereg_w_i == src_idx_i) && w_nonzero;

    always_comb begin
        data_o = reg_data_i;
        if (w_hit_m) begin
            data_o = aluout_m_i;
        end else if (w_hit_w) begin
            data_o = result_w_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall and EX forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] signimm_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic [REG_W-1:0]  rd_d,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic              memwrite_d,
    input  logic              alusrc_d,
    input  logic              regdst_d,
    input  logic [ALU_W-1:0]  alucontrol_d,
    input  logic              flush_e,
    input  logic [DATA_W-1:0] aluout_m,
    input  logic [DATA_W-1:0] result_w,
    input  logic [REG_W-1:0]  writereg_m,
    input  logic [REG_W-1:0]  writereg_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [DATA_W-1:0] srca_e,
    output logic [DATA_W-1:0] srcb_e,
    output logic [ALU_W-1:0]  alucontrol_e,
    output logic [DATA_W-1:0] writedata_e,
    output logic [REG_W-1:0]  writereg_e,
    output logic              regwrite_e,
    output logic              memtoreg_e,
    output logic              memwrite_e,
    output logic              stall_d
);

    ex_reg_t           r_ex_q;
    ex_reg_t           w_ex_d;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    // A load in EX whose destination is read by decode must wait one cycle.
    assign stall_d = r_ex_q.memtoreg && (r_ex_q.rt != '0) &&
                     ((r_ex_q.rt == rs_d) || (r_ex_q.rt == rt_d));

    always_comb begin
        w_ex_d            = ex_bubble();
        if (!(stall_d || flush_e)) begin
            w_ex_d.rd1        = rd1_d;
            w_ex_d.rd2        = rd2_d;
            w_ex_d.signimm    = signimm_d;
            w_ex_d.rs         = rs_d;
            w_ex_d.rt         = rt_d;
            w_ex_d.rd         = rd_d;
            w_ex_d.regwrite   = regwrite_d;
            w_ex_d.memtoreg   = memtoreg_d;
            w_ex_d.memwrite   = memwrite_d;
            w_ex_d.alusrc     = alusrc_d;
            w_ex_d.regdst     = regdst_d;
            w_ex_d.alucontrol = alucontrol_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_q <= ex_bubble();
        end else begin
            r_ex_q <= w_ex_d;
        end
    end

    forward_unit u_fwd_a (
        .src_idx_i    (r_ex_q.rs),
        .reg_data_i   (r_ex_q.rd1),
        .regwrite_m_i (regwrite_m),
        .writereg_m_i (writereg_m),
        .aluout_m_i   (aluout_m),
        .regwrite_w_i (regwrite_w),
        .writereg_w_i (writereg_w),
        .result_w_i   (result_w),
        .data_o       (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .src_idx_i    (r_ex_q.rt),
        .reg_data_i   (r_ex_q.rd2),
        .regwrite_m_i (regwrite_m),
        .writereg_m_i (writereg_m),
        .aluout_m_i   (aluout_m),
        .regwrite_w_i (regwrite_w),
        .writereg_w_i (writereg_w),
        .result_w_i   (result_w),
        .data_o       (w_fwd_b)
    );

    assign srca_e       = w_fwd_a;
    assign writedata_e  = w_fwd_b;
    assign srcb_e       = r_ex_q.alusrc ? r_ex_q.signimm : w_fwd_b;
    assign alucontrol_e = r_ex_q.alucontrol;
    assign writereg_e   = r_ex_q.regdst ? r_ex_q.rd : r_ex_q.rt;
    assign regwrite_e   = r_ex_q.regwrite;
    assign memtoreg_e   = r_ex_q.memtoreg;
    assign memwrite_e   = r_ex_q.memwrite;

endmodule

`default_nettype wire
